full_adder_from_half_adders: RTL and testbench



---
 rtl/full_adder_from_half_adders_if.sv | 21 ++
 rtl/full_adder_from_half_adders.sv | 64 ++++++
 tb/tb_full_adder_from_half_adders.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/full_adder_from_half_adders_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// Ovf is present only when FA_OVERFLOW_EN is defined.
interface full_adder_from_half_adders_if #(
    parameter int unsigned WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] SUM;
    logic             Cout;
`ifdef FA_OVERFLOW_EN
    logic             Ovf;

    modport master (output en, A, B, Cin, input SUM, Cout, Ovf);
    modport slave  (input en, A, B, Cin, output SUM, Cout, Ovf);
`else
    modport master (output en, A, B, Cin, input SUM, Cout);
    modport slave  (input en, A, B, Cin, output SUM, Cout);
`endif
endinterface

// File: rtl/full_adder_from_half_adders.sv
// Registered WIDTH-bit ripple-carry adder; each cell is two half adders plus an OR.
// Define FA_OVERFLOW_EN to add the registered signed-overflow output Ovf.
module full_adder_from_half_adders #(
    parameter int unsigned WIDTH = 1
) (
    input logic                          clk,
    input logic                          rst_n,
    full_adder_from_half_adders_if.slave bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    assign carry[0] = bus.Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic s1;
        logic c1;
        logic c2;

        assign s1           = bus.A[i] ^ bus.B[i];
        assign c1           = bus.A[i] & bus.B[i];
        assign sum_d[i]     = s1 ^ carry[i];
        assign c2           = s1 & carry[i];
        assign carry[i+1]   = c1 | c2;
    end

    assign cout_d = carry[WIDTH];

`ifdef FA_OVERFLOW_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.en) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.Ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (bus.en) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.SUM  = sum_q;
    assign bus.Cout = cout_q;

endmodule

// File: tb/tb_full_adder_from_half_adders.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 adders against an arithmetic reference model.
// Build with FA_OVERFLOW_EN defined to also check Ovf.
module tb_full_adder_from_half_adders;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    full_adder_from_half_adders_if #(.WIDTH(1)) bus1 ();
    full_adder_from_half_adders_if #(.WIDTH(8)) bus8 ();

    full_adder_from_half_adders #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    full_adder_from_half_adders #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected registered outputs after each edge.
    logic       m1_sum;
    logic       m1_cout;
    logic       m1_ovf;
    logic [7:0] m8_sum;
    logic       m8_cout;
    logic       m8_ovf;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_w1"}, 9'({bus1.Cout, bus1.SUM}), 9'({m1_cout, m1_sum}));
        check({tag, "_w8"}, {bus8.Cout, bus8.SUM}, {m8_cout, m8_sum});
`ifdef FA_OVERFLOW_EN
        check({tag, "_w1_ovf"}, 9'(bus1.Ovf), 9'(m1_ovf));
        check({tag, "_w8_ovf"}, 9'(bus8.Ovf), 9'(m8_ovf));
`endif
    endtask

    // Drive one cycle of stimulus, advance the model, clock, then compare.
    task automatic step(input logic r, input logic e,
                        input logic a1, input logic b1, input logic c1,
                        input logic [7:0] a8, input logic [7:0] b8, input logic c8,
                        input string tag);
        int unsigned tot;
        int          s;
        rst_n    = r;
        bus1.en  = e;
        bus1.A   = a1;
        bus1.B   = b1;
        bus1.Cin = c1;
        bus8.en  = e;
        bus8.A   = a8;
        bus8.B   = b8;
        bus8.Cin = c8;
        if (!r) begin
            {m1_cout, m1_sum, m1_ovf} = '0;
            {m8_cout, m8_sum, m8_ovf} = '0;
        end else if (e) begin
            tot     = 32'(a1) + 32'(b1) + 32'(c1);
            m1_sum  = tot[0];
            m1_cout = tot[1];
            s       = (a1 ? -1 : 0) + (b1 ? -1 : 0) + int'(c1);
            m1_ovf  = (s > 0) || (s < -1);
            tot     = 32'(a8) + 32'(b8) + 32'(c8);
            m8_sum  = tot[7:0];
            m8_cout = tot[8];
            s       = int'($signed(a8)) + int'($signed(b8)) + int'(c8);
            m8_ovf  = (s > 127) || (s < -128);
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [1:0] tbl [8];
        logic [2:0] v;
        n_tests = 0;
        n_fail  = 0;
        tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset held for two edges with junk inputs and en=1.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, "reset0");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, "reset1");
        check("reset_w1_const", 9'({bus1.Cout, bus1.SUM}), 9'd0);
        check("reset_w8_const", {bus8.Cout, bus8.SUM}, 9'd0);

        // Exhaustive WIDTH=1 truth table.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            step(1'b1, 1'b1, v[2], v[1], v[0], 8'($urandom), 8'($urandom), 1'($urandom),
                 "sweep");
            check("sweep_tbl", 9'({bus1.Cout, bus1.SUM}), 9'(tbl[i]));
        end

        // Hold with en=0.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0, "hold_cap");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, "hold");
        check("hold_w1_const", 9'({bus1.Cout, bus1.SUM}), 9'b10);
        check("hold_w8_const", {bus8.Cout, bus8.SUM}, 9'h046);

        // Reset beats enable, then normal capture after release.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, "rstprio");
        check("rstprio_const", 9'({bus1.Cout, bus1.SUM}), 9'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, "rstrel");
        check("rstrel_const", 9'({bus1.Cout, bus1.SUM}), 9'b01);

        // WIDTH=8 boundary vectors.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, "wrap_ff");
        check("wrap_ff_const", {bus8.Cout, bus8.SUM}, 9'h100);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h3C, 1'b0, "add_5a3c");
        check("add_5a3c_const", {bus8.Cout, bus8.SUM}, 9'h096);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, "allones");
        check("allones_const", {bus8.Cout, bus8.SUM}, 9'h1FF);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h01, 1'b0, "ovf_pos");
        check("ovf_pos_const", {bus8.Cout, bus8.SUM}, 9'h080);
`ifdef FA_OVERFLOW_EN
        check("ovf_pos_flag", 9'(bus8.Ovf), 9'd1);
`endif
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'hFF, 1'b0, "ovf_neg");
        check("ovf_neg_const", {bus8.Cout, bus8.SUM}, 9'h17F);
`ifdef FA_OVERFLOW_EN
        check("ovf_neg_flag", 9'(bus8.Ovf), 9'd1);
`endif

        // Random operands and enable.
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 1'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
